// File: rtl/photonic_result_collector_if.sv
// Stream-in / word-out bundle for photonic_result_collector.
// m_parity exists only when PHOTONIC_COLLECT_PARITY_EN is defined.
interface photonic_result_collector_if #(
  parameter int PRECISION = 8,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 8
);
  localparam int PACK = OUT_WIDTH / PRECISION;

  logic [PRECISION-1:0]     s_data;
  logic                     s_valid;
  logic                     flush;
  logic [OUT_WIDTH-1:0]     m_data;
  logic [$clog2(PACK):0]    m_lanes;
  logic                     m_valid;
  logic                     m_ready;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;
  logic                     clear_ovf;
`ifdef PHOTONIC_COLLECT_PARITY_EN
  logic                     m_parity;
`endif

  // Collector side: receives the result stream, drives the readout words.
  modport slave (
    input  s_data, s_valid, flush, m_ready, clear_ovf,
    output m_data, m_lanes, m_valid, fifo_level, overflow
`ifdef PHOTONIC_COLLECT_PARITY_EN
    , output m_parity
`endif
  );

  // Producer/host side: drives beats and handshakes, observes the words.
  modport master (
    output s_data, s_valid, flush, m_ready, clear_ovf,
    input  m_data, m_lanes, m_valid, fifo_level, overflow
`ifdef PHOTONIC_COLLECT_PARITY_EN
    , input m_parity
`endif
  );
endinterface

// File: rtl/photonic_result_collector.sv
// Packs PRECISION-bit result beats LSB-first into OUT_WIDTH-bit words, queues them in a
// first-word-fall-through FIFO and drops (sticky overflow) when full. Optional PHOTONIC_COLLECT_PARITY_EN.
module photonic_result_collector #(
  parameter int PRECISION = 8,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  photonic_result_collector_if.slave bus
);
  localparam int PACK = OUT_WIDTH / PRECISION;
  localparam int LCW  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int LNW  = $clog2(PACK) + 1;
  localparam int PTW  = $clog2(DEPTH);
  localparam int LVW  = PTW + 1;

  logic [LCW-1:0]       lc;
  logic [OUT_WIDTH-1:0] partial;
  logic [OUT_WIDTH-1:0] mem_data  [DEPTH];
  logic [LNW-1:0]       mem_lanes [DEPTH];
  logic [PTW-1:0]       wr_ptr;
  logic [PTW-1:0]       rd_ptr;
  logic [LVW-1:0]       level;
  logic                 ovf;

  logic [OUT_WIDTH-1:0] commit_word;
  logic [LNW-1:0]       commit_lanes;
  logic                 last_lane;
  logic                 commit;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  always_comb begin
    commit_word  = partial;
    commit_lanes = LNW'(lc);
    if (bus.s_valid) begin
      commit_word  = partial | (OUT_WIDTH'(bus.s_data) << (int'(lc) * PRECISION));
      commit_lanes = LNW'(lc) + LNW'(1);
    end
  end

  assign last_lane = (lc == LCW'(PACK - 1));
  // A flush with a beat on the last lane is just an ordinary full commit.
  assign commit    = (bus.s_valid && (last_lane || bus.flush))
                   || (bus.flush && !bus.s_valid && (lc != '0));
  assign empty     = (level == '0);
  assign full      = (level == LVW'(DEPTH));
  assign pop       = !empty && bus.m_ready;
  assign push      = commit && (!full || pop);
  assign drop      = commit && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc      <= '0;
      partial <= '0;
    end else if (commit) begin
      lc      <= '0;
      partial <= '0;
    end else if (bus.s_valid) begin
      lc      <= lc + LCW'(1);
      partial <= commit_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVW'(1);
        2'b01:   level <= level - LVW'(1);
        default: level <= level;
      endcase
      if (drop)               ovf <= 1'b1;
      else if (bus.clear_ovf) ovf <= 1'b0;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= commit_word;
      mem_lanes[wr_ptr] <= commit_lanes;
    end
  end

  assign bus.m_valid    = !empty;
  assign bus.m_data     = empty ? '0 : mem_data[rd_ptr];
  assign bus.m_lanes    = empty ? '0 : mem_lanes[rd_ptr];
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;

`ifdef PHOTONIC_COLLECT_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_par[wr_ptr] <= (^commit_word) ^ (^commit_lanes);
  end

  assign bus.m_parity = empty ? 1'b0 : mem_par[rd_ptr];
`endif
endmodule

// File: tb/tb_photonic_result_collector.sv
// Self-checking bench for photonic_result_collector: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_photonic_result_collector;
  localparam int PRECISION = 8;
  localparam int OUT_WIDTH = 32;
  localparam int DEPTH     = 8;
  localparam int PACK      = OUT_WIDTH / PRECISION;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  photonic_result_collector_if #(.PRECISION(PRECISION), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)) bus ();

  photonic_result_collector #(.PRECISION(PRECISION), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] w;
    int          l;
  } ent_t;

  ent_t        fq[$];
  logic [7:0]  beats[$];
  bit          movf = 1'b0;

  typedef struct {
    bit          sv;
    logic [7:0]  sd;
    bit          fl;
    bit          mr;
    bit          co;
    bit          ev;
    logic [31:0] ed;
    int          el;
    int          elv;
    bit          eo;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: beats gather in a list; a full list or a flush forms a word.
  task automatic model_edge(input bit sv, input logic [7:0] sd, input bit fl, input bit mr, input bit co);
    bit   pop;
    bit   commit;
    bit   drop;
    ent_t e;
    pop    = (fq.size() > 0) && mr;
    commit = 1'b0;
    drop   = 1'b0;
    e.w    = '0;
    e.l    = 0;
    if (sv) beats.push_back(sd);
    if (beats.size() == PACK || (fl && beats.size() > 0)) begin
      foreach (beats[i]) e.w[i*PRECISION +: PRECISION] = beats[i];
      e.l = beats.size();
      beats.delete();
      commit = 1'b1;
    end
    if (pop) void'(fq.pop_front());
    if (commit) begin
      if (fq.size() < DEPTH) fq.push_back(e);
      else drop = 1'b1;
    end
    if (drop)    movf = 1'b1;
    else if (co) movf = 1'b0;
  endtask

  task automatic compare_model();
    logic [31:0] ew;
    int          el;
    ew = (fq.size() > 0) ? fq[0].w : 32'h0;
    el = (fq.size() > 0) ? fq[0].l : 0;
    chk("m_valid", 64'(bus.m_valid), 64'(fq.size() > 0));
    chk("m_data", 64'(bus.m_data), 64'(ew));
    chk("m_lanes", 64'(bus.m_lanes), 64'(el));
    chk("fifo_level", 64'(bus.fifo_level), 64'(fq.size()));
    chk("overflow", 64'(bus.overflow), 64'(movf));
`ifdef PHOTONIC_COLLECT_PARITY_EN
    chk("m_parity", 64'(bus.m_parity), (fq.size() > 0) ? 64'((^ew) ^ (^(3'(el)))) : 64'(0));
`endif
  endtask

  task automatic step(input bit sv, input logic [7:0] sd, input bit fl, input bit mr, input bit co);
    bus.s_valid   = sv;
    bus.s_data    = sd;
    bus.flush     = fl;
    bus.m_ready   = mr;
    bus.clear_ovf = co;
    @(posedge clk);
    model_edge(sv, sd, fl, mr, co);
    #1;
    compare_model();
  endtask

  task automatic push_word(input logic [7:0] base, input bit mr_early, input bit mr_last, input bit co_last);
    for (int j = 0; j < PACK; j++)
      step(1'b1, base + 8'(j), 1'b0, (j == PACK-1) ? mr_last : mr_early, (j == PACK-1) ? co_last : 1'b0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] ew;
    int          thr;

    bus.s_valid = 0; bus.s_data = 0; bus.flush = 0; bus.m_ready = 0; bus.clear_ovf = 0;

    tbl[0]  = '{1, 8'h11, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[1]  = '{1, 8'h22, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[2]  = '{1, 8'h33, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[3]  = '{1, 8'h44, 0, 1, 0, 1, 32'h44332211, 4, 1, 0};
    tbl[4]  = '{0, 8'h00, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[5]  = '{1, 8'hAA, 0, 0, 0, 0, 32'h0,        0, 0, 0};
    tbl[6]  = '{1, 8'hBB, 0, 0, 0, 0, 32'h0,        0, 0, 0};
    tbl[7]  = '{0, 8'h00, 1, 0, 0, 1, 32'h0000BBAA, 2, 1, 0};
    tbl[8]  = '{1, 8'h01, 0, 0, 0, 1, 32'h0000BBAA, 2, 1, 0};
    tbl[9]  = '{1, 8'h02, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[10] = '{1, 8'h03, 0, 0, 0, 0, 32'h0,        0, 0, 0};
    tbl[11] = '{1, 8'h04, 0, 0, 0, 1, 32'h04030201, 4, 1, 0};
    tbl[12] = '{0, 8'h00, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[13] = '{1, 8'h01, 0, 0, 0, 0, 32'h0,        0, 0, 0};
    tbl[14] = '{1, 8'h02, 0, 0, 0, 0, 32'h0,        0, 0, 0};
    tbl[15] = '{1, 8'h03, 1, 0, 0, 1, 32'h00030201, 3, 1, 0};
    tbl[16] = '{1, 8'h10, 0, 0, 0, 1, 32'h00030201, 3, 1, 0};
    tbl[17] = '{1, 8'h20, 0, 0, 0, 1, 32'h00030201, 3, 1, 0};
    tbl[18] = '{1, 8'h30, 0, 0, 0, 1, 32'h00030201, 3, 1, 0};
    tbl[19] = '{1, 8'h40, 1, 0, 0, 1, 32'h00030201, 3, 2, 0};
    tbl[20] = '{0, 8'h00, 0, 1, 0, 1, 32'h40302010, 4, 1, 0};
    tbl[21] = '{0, 8'h00, 0, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[22] = '{0, 8'h00, 1, 1, 0, 0, 32'h0,        0, 0, 0};
    tbl[23] = '{0, 8'h00, 0, 1, 0, 0, 32'h0,        0, 0, 0};

    // Reset state
    @(posedge clk); #1;
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_m_data", 64'(bus.m_data), 64'(0));
    chk("rst_m_lanes", 64'(bus.m_lanes), 64'(0));
    chk("rst_fifo_level", 64'(bus.fifo_level), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].fl, tbl[i].mr, tbl[i].co);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.m_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 64'(bus.m_data), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_lanes", i), 64'(bus.m_lanes), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_level", i), 64'(bus.fifo_level), 64'(tbl[i].elv));
      chk($sformatf("tbl%0d_ovf", i), 64'(bus.overflow), 64'(tbl[i].eo));
    end

    // Overflow: fill, drop, drop with simultaneous clear (set wins), drain in order
    for (int k = 0; k < DEPTH; k++) push_word(8'(8'h40 + k*4), 1'b0, 1'b0, 1'b0);
    chk("full_level", 64'(bus.fifo_level), 64'(8));
    chk("full_ovf", 64'(bus.overflow), 64'(0));
    push_word(8'hC0, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", 64'(bus.overflow), 64'(1));
    chk("drop_level", 64'(bus.fifo_level), 64'(8));
    push_word(8'hD0, 1'b0, 1'b0, 1'b1);
    chk("drop_clear_ovf", 64'(bus.overflow), 64'(1));
    for (int k = 0; k < DEPTH; k++) begin
      b  = 8'(8'h40 + k*4);
      ew = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      chk($sformatf("drain%0d_data", k), 64'(bus.m_data), 64'(ew));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("drained_level", 64'(bus.fifo_level), 64'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 64'(bus.overflow), 64'(0));

    // Commit into a full FIFO together with a pop
    for (int k = 0; k < DEPTH; k++) push_word(8'(8'h80 + k*4), 1'b0, 1'b0, 1'b0);
    push_word(8'hE0, 1'b0, 1'b1, 1'b0);
    chk("fullpop_level", 64'(bus.fifo_level), 64'(8));
    chk("fullpop_ovf", 64'(bus.overflow), 64'(0));
    chk("fullpop_head", 64'(bus.m_data), 64'(32'h87868584));
    for (int k = 0; k < DEPTH - 1; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("fullpop_last", 64'(bus.m_data), 64'(32'hE3E2E1E0));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("fullpop_empty", 64'(bus.fifo_level), 64'(0));

    // Asynchronous reset with words queued and a partial word pending
    push_word(8'h50, 1'b0, 1'b0, 1'b0);
    push_word(8'h60, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h70 + j), 1'b0, 1'b0, 1'b0);
    chk("prerst_level", 64'(bus.fifo_level), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.m_valid), 64'(0));
    chk("midrst_level", 64'(bus.fifo_level), 64'(0));
    chk("midrst_data", 64'(bus.m_data), 64'(0));
    fq.delete();
    beats.delete();
    movf = 1'b0;
    bus.s_valid = 0; bus.flush = 0; bus.m_ready = 0; bus.clear_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) step(1'b1, 8'(8'h05 + j), 1'b0, 1'b0, 1'b0);
    chk("postrst_data", 64'(bus.m_data), 64'(32'h08070605));
    chk("postrst_lanes", 64'(bus.m_lanes), 64'(4));
    chk("postrst_level", 64'(bus.fifo_level), 64'(1));

    // Randomized traffic with shifting host readiness
    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < thr, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/photonic_result_collector.md
Name: photonic_result_collector

Overview:
- Receiving end of the layer-pipeline output stream.
- Accepts PRECISION-bit results on a valid-only interface with no backpressure.
- Packs them LSB-first into OUT_WIDTH-bit words and buffers the words in a FIFO.
- Presents the words to the host/readout side on a valid/ready handshake.
- Sits between the last photonic layer and the host interface. Drops and flags words when the host stalls too long.

Parameters:
PRECISION, 8, bits per result beat
OUT_WIDTH, 32, output word width; must be an integer multiple of PRECISION; PACK = OUT_WIDTH/PRECISION (default 4)
DEPTH, 8, FIFO depth in words; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_data  input  PRECISION  result beat from the network
s_valid  input  1  s_data valid this cycle; no ready, beat is always consumed
flush  input  1  commit a partially filled word
m_data  output  OUT_WIDTH  packed word at FIFO head
m_lanes  output  $clog2(PACK)+1  number of valid lanes in m_data (1..PACK)
m_valid  output  1  FIFO not empty
m_ready  input  1  host accepts m_data
fifo_level  output  $clog2(DEPTH)+1  words currently stored (0..DEPTH)
overflow  output  1  sticky: a committed word was dropped
clear_ovf  input  1  clears overflow

Behaviour:
- Reset: asynchronous, active-low; all state clears immediately.
  - Outputs: m_valid=0, m_data=0, m_lanes=0, fifo_level=0, overflow=0.
  - Internal: lane counter=0, partial word=0, FIFO pointers=0.
- Packer:
  - Lane counter lc runs 0..PACK-1.
  - On s_valid, s_data goes to bits [lc*PRECISION +: PRECISION].
  - When lc==PACK-1 with s_valid, the word commits with lanes=PACK and lc returns to 0.
- Flush:
  - flush with lc>0 and no s_valid: commits the partial word with lanes=lc. Unused upper lanes are 0. lc becomes 0.
  - flush and s_valid in the same cycle: the beat is included first, then the word commits with lanes=lc+1. If lc+1==PACK this is an ordinary full commit; no second commit follows.
  - flush with lc==0 and no s_valid: no-op.
- Commit timing:
  - The commit word is formed from the partial register plus the current beat.
  - It is written into the FIFO on the same edge that samples the final beat or flush.
  - m_valid rises the next cycle when the FIFO was empty: 1-cycle latency.
- FIFO:
  - First-word-fall-through; m_data and m_lanes always reflect the head.
  - Pop occurs when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_lanes hold stable.
  - m_valid=1 iff fifo_level>0.
- Full boundary:
  - Commit while full with a pop in the same cycle: accepted, level unchanged.
  - Commit while full without a pop: the word is discarded, overflow is set, and the packer still clears.
  - The FIFO contents and order are untouched by a drop.
- Empty boundary: m_ready while empty is ignored; the level never underflows.
- Pointers wrap modulo DEPTH; level is tracked separately so that full and empty are distinct.
- overflow: clear_ovf clears it. A drop in the same cycle as clear_ovf leaves overflow=1 (set wins).
- Reset mid-word discards the partial word. Reset mid-transfer empties the FIFO.

Optional Feature:
- Macro: PHOTONIC_COLLECT_PARITY_EN.
- Defined:
  - Adds output m_parity (1 bit) = XOR of all bits of the committed word and its lanes count.
  - m_parity is computed at commit and stored in the FIFO alongside the word, so it follows the head with m_data.
  - Reset value 0.
- Undefined: no m_parity port and no parity storage; all other behaviour is identical.

Test Plan:
- Stream: beats 0x11,0x22,0x33,0x44 on consecutive cycles, m_ready=1 -> one cycle after the 0x44 edge, m_valid=1, m_data=0x44332211, m_lanes=4; popped, level returns to 0.
- Partial flush: beats 0xAA,0xBB, then flush alone -> m_data=0x0000BBAA, m_lanes=2; a following 4-beat group packs from lane 0.
- Flush with beat: beats 0x01,0x02, then 0x03 with flush -> m_data=0x00030201, m_lanes=3, exactly one word. Then 3 beats plus a flush on the 4th beat -> one word with m_lanes=4.
- Overflow: m_ready=0, push 8 full words -> fifo_level=8. A 9th word is dropped: overflow=1, level stays 8. Raise m_ready -> the original 8 words drain in order. clear_ovf -> overflow=0.
- Full plus pop: FIFO full, m_ready=1 on the same cycle as a commit -> no drop, overflow stays 0, level stays 8, head advances.
- Reset mid-operation: 3 beats in, 2 words queued, assert rst_n=0 -> m_valid=0, level=0 immediately. After release, beats 0x05..0x08 -> m_data=0x08070605, m_lanes=4.
